uart_buffered_port: RTL and testbench

- Parametrised successor to the single-byte UART wrapper.
- Contains its own RX and TX serial engines with selectable parity and stop bits.
- Provides a FIFO on each direction with ready/valid handshakes, sticky error flags, and a runtime-selectable echo mode.
- Sits between the board UART pins and the DDS control logic; the control logic consumes command bytes and returns status bytes.

---
 rtl/uart_buffered_port.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_buffered_port.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_buffered_port.sv
// uart_buffered_port: UART with built-in RX/TX serial engines, a FIFO in each
// direction, sticky receive error flags and a runtime echo mode.
//
// Ports:
//   clk, resetn      system clock, synchronous active-low reset
//   uart_rxd         asynchronous serial input (2-flop synchronised)
//   uart_txd         serial output, idle high
//   rx_data/valid    head of the first-word-fall-through RX FIFO
//   rx_ready         pops the RX head when rx_valid is high
//   tx_data/valid    byte to enqueue into the TX FIFO
//   tx_ready         TX FIFO not full and echo mode off
//   echo_en          every accepted RX byte is also queued for transmit
//   rx_count         RX FIFO occupancy
//   tx_count         TX FIFO occupancy
//   tx_busy          TX engine mid-frame
//   rx_overrun       sticky: accepted byte dropped, RX FIFO full
//   rx_parity_err    sticky: parity mismatch
//   rx_frame_err     sticky: stop bit sampled low
//   err_clr          clears the sticky flags (a same-cycle set wins)
module uart_buffered_port #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rxd,
  output logic                          uart_txd,
  output logic [PAYLOAD_BITS-1:0]       rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic [PAYLOAD_BITS-1:0]       tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          echo_en,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          tx_busy,
  output logic                          rx_overrun,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  input  logic                          err_clr
);

  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int CNT_W = $clog2(CPB);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity bit that belongs with the data: odd mode makes data+parity odd.
  function automatic logic parity_bit(input logic [PAYLOAD_BITS-1:0] data);
    logic ones;
    ones = ^data;
    if (PARITY == 1) begin
      parity_bit = ~ones;
    end else begin
      parity_bit = ones;
    end
  endfunction

  // ---------------- RX engine ----------------
  logic                    rxd_meta_r, rxd_sync_r;
  state_t                  rx_state_r, rx_state_s;
  logic [CNT_W-1:0]        rx_cnt_r, rx_cnt_s;
  logic [IDX_W-1:0]        rx_idx_r, rx_idx_s;
  logic [PAYLOAD_BITS-1:0] rx_shift_r, rx_shift_s;
  logic                    rx_par_r, rx_par_s;
  logic                    rx_done_s, rx_ferr_s, rx_perr_s, rx_tick_s;
  logic                    rx_push_r;

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
    end else begin
      rxd_meta_r <= uart_rxd;
      rxd_sync_r <= rxd_meta_r;
    end
  end

  // RX next-state logic: start detect, mid-bit sampling, frame verdict.
  always_comb begin
    rx_state_s = rx_state_r;
    rx_cnt_s   = rx_cnt_r;
    rx_idx_s   = rx_idx_r;
    rx_shift_s = rx_shift_r;
    rx_par_s   = rx_par_r;
    rx_done_s  = 1'b0;
    rx_ferr_s  = 1'b0;
    rx_perr_s  = 1'b0;
    rx_tick_s  = (rx_cnt_r == CNT_W'(CPB - 1));
    case (rx_state_r)
      ST_IDLE: begin
        rx_cnt_s = '0;
        rx_idx_s = '0;
        if (!rxd_sync_r) begin
          rx_state_s = ST_START;
        end else begin
          rx_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        // Half-bit check rejects short glitches; later samples land mid-bit.
        if (rx_cnt_r == CNT_W'(CPB / 2)) begin
          rx_cnt_s = '0;
          if (rxd_sync_r) begin
            rx_state_s = ST_IDLE;
          end else begin
            rx_state_s = ST_DATA;
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (rx_tick_s) begin
          rx_cnt_s   = '0;
          rx_shift_s = {rxd_sync_r, rx_shift_r[PAYLOAD_BITS-1:1]};
          if (rx_idx_r == IDX_W'(PAYLOAD_BITS - 1)) begin
            rx_idx_s = '0;
            if (PARITY != 0) begin
              rx_state_s = ST_PARITY;
            end else begin
              rx_state_s = ST_STOP;
            end
          end else begin
            rx_idx_s = rx_idx_r + IDX_W'(1);
          end
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        if (rx_tick_s) begin
          rx_cnt_s   = '0;
          rx_par_s   = rxd_sync_r;
          rx_state_s = ST_STOP;
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_W'(1);
        end
      end
      ST_STOP: begin
        // Only the first stop bit is checked, whatever STOP_BITS is.
        if (rx_tick_s) begin
          rx_cnt_s   = '0;
          rx_state_s = ST_IDLE;
          rx_ferr_s  = ~rxd_sync_r;
          if (PARITY != 0) begin
            rx_perr_s = (rx_par_r != parity_bit(rx_shift_r));
          end else begin
            rx_perr_s = 1'b0;
          end
          rx_done_s = rxd_sync_r & ~rx_perr_s;
        end else begin
          rx_cnt_s = rx_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        rx_state_s = ST_IDLE;
        rx_cnt_s   = '0;
      end
    endcase
  end

  // RX engine state register; rx_push_r delays the push one cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_state_r <= ST_IDLE;
      rx_cnt_r   <= '0;
      rx_idx_r   <= '0;
      rx_shift_r <= '0;
      rx_par_r   <= 1'b0;
      rx_push_r  <= 1'b0;
    end else begin
      rx_state_r <= rx_state_s;
      rx_cnt_r   <= rx_cnt_s;
      rx_idx_r   <= rx_idx_s;
      rx_shift_r <= rx_shift_s;
      rx_par_r   <= rx_par_s;
      rx_push_r  <= rx_done_s;
    end
  end

  // ---------------- RX FIFO ----------------
  // rx_shift_r still holds the byte during the push cycle: the engine is idle.
  logic [PAYLOAD_BITS-1:0] rx_mem_r [FIFO_DEPTH];
  logic [AW-1:0]           rx_wr_ptr_r, rx_rd_ptr_r;
  logic [CW-1:0]           rx_count_r, rx_count_s;
  logic                    rx_valid_r;
  logic                    rx_full_s, rx_pop_s, rx_wr_s, rx_ovr_s;

  // RX FIFO push/pop decisions and next occupancy.
  always_comb begin
    rx_full_s = (rx_count_r == CW'(FIFO_DEPTH));
    rx_pop_s  = rx_valid_r & rx_ready;
    rx_wr_s   = rx_push_r & (~rx_full_s | rx_pop_s);
    rx_ovr_s  = rx_push_r & rx_full_s & ~rx_pop_s;
    case ({rx_wr_s, rx_pop_s})
      2'b10:   rx_count_s = rx_count_r + CW'(1);
      2'b01:   rx_count_s = rx_count_r - CW'(1);
      default: rx_count_s = rx_count_r;
    endcase
  end

  // RX FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_wr_ptr_r <= '0;
      rx_rd_ptr_r <= '0;
      rx_count_r  <= '0;
      rx_valid_r  <= 1'b0;
    end else begin
      if (rx_wr_s) rx_wr_ptr_r <= rx_wr_ptr_r + AW'(1);
      if (rx_pop_s) rx_rd_ptr_r <= rx_rd_ptr_r + AW'(1);
      rx_count_r <= rx_count_s;
      rx_valid_r <= (rx_count_s != '0);
    end
  end

  // RX FIFO storage.
  always_ff @(posedge clk) begin
    if (rx_wr_s) rx_mem_r[rx_wr_ptr_r] <= rx_shift_r;
  end

  // RX head presented only while valid so it reads zero after reset.
  always_comb begin
    if (rx_valid_r) begin
      rx_data = rx_mem_r[rx_rd_ptr_r];
    end else begin
      rx_data = '0;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [PAYLOAD_BITS-1:0] tx_mem_r [FIFO_DEPTH];
  logic [AW-1:0]           tx_wr_ptr_r, tx_rd_ptr_r;
  logic [CW-1:0]           tx_count_r, tx_count_s;
  logic                    tx_full_s, tx_wr_s, tx_pop_s;
  logic [PAYLOAD_BITS-1:0] tx_wdata_s;

  // TX FIFO write source (host or echo) and next occupancy.
  always_comb begin
    tx_full_s = (tx_count_r == CW'(FIFO_DEPTH));
    if (echo_en) begin
      // Echo copy is dropped silently when the TX FIFO is full.
      tx_wr_s    = rx_push_r & ~tx_full_s;
      tx_wdata_s = rx_shift_r;
    end else begin
      tx_wr_s    = tx_valid & ~tx_full_s;
      tx_wdata_s = tx_data;
    end
    case ({tx_wr_s, tx_pop_s})
      2'b10:   tx_count_s = tx_count_r + CW'(1);
      2'b01:   tx_count_s = tx_count_r - CW'(1);
      default: tx_count_s = tx_count_r;
    endcase
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
      tx_count_r  <= '0;
    end else begin
      if (tx_wr_s) tx_wr_ptr_r <= tx_wr_ptr_r + AW'(1);
      if (tx_pop_s) tx_rd_ptr_r <= tx_rd_ptr_r + AW'(1);
      tx_count_r <= tx_count_s;
    end
  end

  // TX FIFO storage.
  always_ff @(posedge clk) begin
    if (tx_wr_s) tx_mem_r[tx_wr_ptr_r] <= tx_wdata_s;
  end

  // ---------------- TX engine ----------------
  state_t                  tx_state_r, tx_state_s;
  logic [CNT_W-1:0]        tx_cnt_r, tx_cnt_s;
  logic [IDX_W-1:0]        tx_idx_r, tx_idx_s;
  logic [PAYLOAD_BITS-1:0] tx_shift_r, tx_shift_s;
  logic                    tx_par_r, tx_par_s;
  logic                    tx_txd_s, tx_tick_s;
  logic                    tx_txd_r, tx_busy_r;

  // TX next-state logic; the line level is registered one cycle later.
  always_comb begin
    tx_state_s = tx_state_r;
    tx_cnt_s   = tx_cnt_r;
    tx_idx_s   = tx_idx_r;
    tx_shift_s = tx_shift_r;
    tx_par_s   = tx_par_r;
    tx_pop_s   = 1'b0;
    tx_txd_s   = 1'b1;
    tx_tick_s  = (tx_cnt_r == CNT_W'(CPB - 1));
    case (tx_state_r)
      ST_IDLE: begin
        tx_cnt_s = '0;
        tx_idx_s = '0;
        if (tx_count_r != '0) begin
          tx_pop_s   = 1'b1;
          tx_shift_s = tx_mem_r[tx_rd_ptr_r];
          tx_par_s   = parity_bit(tx_mem_r[tx_rd_ptr_r]);
          tx_state_s = ST_START;
        end else begin
          tx_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        tx_txd_s = 1'b0;
        if (tx_tick_s) begin
          tx_cnt_s   = '0;
          tx_state_s = ST_DATA;
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        tx_txd_s = tx_shift_r[0];
        if (tx_tick_s) begin
          tx_cnt_s   = '0;
          tx_shift_s = tx_shift_r >> 1;
          if (tx_idx_r == IDX_W'(PAYLOAD_BITS - 1)) begin
            tx_idx_s = '0;
            if (PARITY != 0) begin
              tx_state_s = ST_PARITY;
            end else begin
              tx_state_s = ST_STOP;
            end
          end else begin
            tx_idx_s = tx_idx_r + IDX_W'(1);
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_W'(1);
        end
      end
      ST_PARITY: begin
        tx_txd_s = tx_par_r;
        if (tx_tick_s) begin
          tx_cnt_s   = '0;
          tx_state_s = ST_STOP;
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_W'(1);
        end
      end
      ST_STOP: begin
        tx_txd_s = 1'b1;
        if (tx_tick_s) begin
          tx_cnt_s = '0;
          if (tx_idx_r == IDX_W'(STOP_BITS - 1)) begin
            tx_idx_s   = '0;
            tx_state_s = ST_IDLE;
          end else begin
            tx_idx_s = tx_idx_r + IDX_W'(1);
          end
        end else begin
          tx_cnt_s = tx_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        tx_state_s = ST_IDLE;
        tx_cnt_s   = '0;
      end
    endcase
  end

  // TX engine state and registered line/busy outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state_r <= ST_IDLE;
      tx_cnt_r   <= '0;
      tx_idx_r   <= '0;
      tx_shift_r <= '0;
      tx_par_r   <= 1'b0;
      tx_txd_r   <= 1'b1;
      tx_busy_r  <= 1'b0;
    end else begin
      tx_state_r <= tx_state_s;
      tx_cnt_r   <= tx_cnt_s;
      tx_idx_r   <= tx_idx_s;
      tx_shift_r <= tx_shift_s;
      tx_par_r   <= tx_par_s;
      tx_txd_r   <= tx_txd_s;
      tx_busy_r  <= (tx_state_r != ST_IDLE);
    end
  end

  // ---------------- Sticky flags ----------------
  logic rx_overrun_r, rx_parity_err_r, rx_frame_err_r;

  // Sticky error flags; a set event outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_overrun_r    <= 1'b0;
      rx_parity_err_r <= 1'b0;
      rx_frame_err_r  <= 1'b0;
    end else begin
      rx_overrun_r    <= rx_ovr_s  | (rx_overrun_r    & ~err_clr);
      rx_parity_err_r <= rx_perr_s | (rx_parity_err_r & ~err_clr);
      rx_frame_err_r  <= rx_ferr_s | (rx_frame_err_r  & ~err_clr);
    end
  end

  assign uart_txd      = tx_txd_r;
  assign tx_busy       = tx_busy_r;
  assign rx_valid      = rx_valid_r;
  assign rx_count      = rx_count_r;
  assign tx_count      = tx_count_r;
  assign tx_ready      = ~echo_en & ~tx_full_s;
  assign rx_overrun    = rx_overrun_r;
  assign rx_parity_err = rx_parity_err_r;
  assign rx_frame_err  = rx_frame_err_r;

endmodule

// File: tb/tb_uart_buffered_port.sv
// Directed bench for uart_buffered_port. Two instances at 10 cycles/bit with a
// 4-entry FIFO: dut_a has no parity and one stop bit, dut_b has even parity
// and two stop bits.
module tb_uart_buffered_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       a_rxd, a_txd, a_rx_valid, a_rx_ready, a_tx_valid, a_tx_ready;
  logic       a_echo_en, a_tx_busy, a_ovr, a_perr, a_ferr, a_err_clr;
  logic [7:0] a_rx_data, a_tx_data;
  logic [2:0] a_rx_count, a_tx_count;
  logic       b_rxd, b_txd, b_rx_valid, b_rx_ready, b_tx_valid, b_tx_ready;
  logic       b_echo_en, b_tx_busy, b_ovr, b_perr, b_ferr, b_err_clr;
  logic [7:0] b_rx_data, b_tx_data;
  logic [2:0] b_rx_count, b_tx_count;

  int n_vec = 0;
  int n_bad = 0;

  uart_buffered_port #(
    .CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8),
    .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .resetn(resetn), .uart_rxd(a_rxd), .uart_txd(a_txd),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .echo_en(a_echo_en), .rx_count(a_rx_count), .tx_count(a_tx_count),
    .tx_busy(a_tx_busy), .rx_overrun(a_ovr), .rx_parity_err(a_perr),
    .rx_frame_err(a_ferr), .err_clr(a_err_clr)
  );

  uart_buffered_port #(
    .CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8),
    .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .resetn(resetn), .uart_rxd(b_rxd), .uart_txd(b_txd),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .echo_en(b_echo_en), .rx_count(b_rx_count), .tx_count(b_tx_count),
    .tx_busy(b_tx_busy), .rx_overrun(b_ovr), .rx_parity_err(b_perr),
    .rx_frame_err(b_ferr), .err_clr(b_err_clr)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_rxd(input bit sel, input logic v);
    if (sel) b_rxd = v;
    else     a_rxd = v;
  endtask

  function automatic logic get_txd(input bit sel);
    return sel ? b_txd : a_txd;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? b_tx_busy : a_tx_busy;
  endfunction

  function automatic logic [2:0] get_tx_count(input bit sel);
    return sel ? b_tx_count : a_tx_count;
  endfunction

  // Serial frame: start, 8 data LSB first, optional parity, one stop bit.
  task automatic send_serial(input bit sel, input logic [7:0] d, input bit par_en,
                             input logic par, input logic stop_v);
    drive_rxd(sel, 1'b0);
    tick(10);
    for (int i = 0; i < 8; i++) begin
      drive_rxd(sel, d[i]);
      tick(10);
    end
    if (par_en) begin
      drive_rxd(sel, par);
      tick(10);
    end
    drive_rxd(sel, stop_v);
    tick(10);
    drive_rxd(sel, 1'b1);
  endtask

  // Writes one byte (edge N) and checks latency, bits, parity and stop length.
  task automatic tx_frame_check(input bit sel, input logic [7:0] d, input bit par_en,
                                input logic par, input int nstop);
    logic [7:0] got;
    if (sel) begin b_tx_data = d; b_tx_valid = 1'b1; end
    else     begin a_tx_data = d; a_tx_valid = 1'b1; end
    tick(1);
    a_tx_valid = 1'b0;
    b_tx_valid = 1'b0;
    check_vec("tx_count_after_write", get_tx_count(sel), 1);
    check_vec("txd_idle_n1", get_txd(sel), 1);
    tick(1);
    check_vec("txd_idle_pop_edge", get_txd(sel), 1);
    check_vec("tx_count_after_pop", get_tx_count(sel), 0);
    tick(1);
    check_vec("txd_start_n2", get_txd(sel), 0);
    tick(5);
    check_vec("txd_start_mid", get_txd(sel), 0);
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(10);
      got[i] = get_txd(sel);
    end
    check_vec("tx_data_bits", got, d);
    if (par_en) begin
      tick(10);
      check_vec("tx_parity_bit", get_txd(sel), par);
    end
    for (int s = 0; s < nstop; s++) begin
      tick(10);
      check_vec("tx_stop_bit", get_txd(sel), 1);
    end
    tick(4);
    check_vec("tx_busy_last_cycle", get_busy(sel), 1);
    tick(1);
    check_vec("tx_busy_end", get_busy(sel), 0);
  endtask

  initial begin
    logic [7:0] got;
    bit         found;
    logic       rdy_seen;

    resetn = 1'b0;
    a_rxd = 1'b1; a_rx_ready = 1'b0; a_tx_valid = 1'b0; a_tx_data = 8'h00;
    a_echo_en = 1'b1; a_err_clr = 1'b0;
    b_rxd = 1'b1; b_rx_ready = 1'b0; b_tx_valid = 1'b0; b_tx_data = 8'h00;
    b_echo_en = 1'b0; b_err_clr = 1'b0;
    tick(3);

    // Reset state
    check_vec("rst_txd", a_txd, 1);
    check_vec("rst_rx_valid", a_rx_valid, 0);
    check_vec("rst_rx_data", a_rx_data, 0);
    check_vec("rst_counts", {a_rx_count, a_tx_count}, 0);
    check_vec("rst_busy", a_tx_busy, 0);
    check_vec("rst_flags", {a_ovr, a_perr, a_ferr}, 0);
    check_vec("rst_tx_ready_echo", a_tx_ready, 0);
    a_echo_en = 1'b0;
    #1;
    check_vec("rst_tx_ready_noecho", a_tx_ready, 1);
    resetn = 1'b1;
    tick(2);

    // Scenario 1: receive 0xA5, then pop it
    send_serial(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    tick(2);
    check_vec("s1_rx_valid", a_rx_valid, 1);
    check_vec("s1_rx_data", a_rx_data, 8'hA5);
    check_vec("s1_rx_count", a_rx_count, 1);
    check_vec("s1_no_ferr", a_ferr, 0);
    a_rx_ready = 1'b1;
    tick(1);
    a_rx_ready = 1'b0;
    check_vec("s1_pop_count", a_rx_count, 0);
    check_vec("s1_pop_valid", a_rx_valid, 0);

    // Scenario 2: TX latency and framing (1 stop; even parity + 2 stops)
    tx_frame_check(1'b0, 8'h3C, 1'b0, 1'b0, 1);
    tx_frame_check(1'b1, 8'h3C, 1'b1, 1'b0, 2);

    // Scenario 3: even parity receive, good then bad parity
    send_serial(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    tick(2);
    check_vec("s3_good_count", b_rx_count, 1);
    check_vec("s3_good_data", b_rx_data, 8'h07);
    check_vec("s3_good_perr", b_perr, 0);
    send_serial(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    tick(2);
    check_vec("s3_bad_perr", b_perr, 1);
    check_vec("s3_bad_count", b_rx_count, 1);
    b_err_clr = 1'b1;
    tick(1);
    b_err_clr = 1'b0;
    check_vec("s3_perr_cleared", b_perr, 0);

    // Scenario 4: overrun on the fifth byte
    for (int v = 1; v <= 4; v++) send_serial(1'b0, 8'(v), 1'b0, 1'b0, 1'b1);
    tick(2);
    check_vec("s4_full_count", a_rx_count, 4);
    check_vec("s4_no_ovr_yet", a_ovr, 0);
    send_serial(1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
    tick(2);
    check_vec("s4_ovr_count", a_rx_count, 4);
    check_vec("s4_ovr_flag", a_ovr, 1);
    for (int v = 1; v <= 4; v++) begin
      check_vec("s4_head", a_rx_data, v);
      a_rx_ready = 1'b1;
      tick(1);
      a_rx_ready = 1'b0;
    end
    check_vec("s4_drained", a_rx_count, 0);

    // Scenario 5: framing error, then idle-line glitch
    a_err_clr = 1'b1;
    tick(1);
    a_err_clr = 1'b0;
    check_vec("s5_ovr_cleared", a_ovr, 0);
    send_serial(1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
    tick(2);
    check_vec("s5_ferr", a_ferr, 1);
    check_vec("s5_ferr_no_push", a_rx_count, 0);
    tick(20);
    a_err_clr = 1'b1;
    tick(1);
    a_err_clr = 1'b0;
    check_vec("s5_ferr_cleared", a_ferr, 0);
    a_rxd = 1'b0;
    tick(3);
    a_rxd = 1'b1;
    tick(150);
    check_vec("s5_glitch_count", a_rx_count, 0);
    check_vec("s5_glitch_flags", {a_ovr, a_perr, a_ferr}, 0);

    // Scenario 6: echo 0x5A, then reset mid-frame
    a_echo_en = 1'b1;
    tick(1);
    rdy_seen = a_tx_ready;
    send_serial(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      rdy_seen = rdy_seen | a_tx_ready;
      if (!a_txd) found = 1'b1;
    end
    check_vec("s6_echo_start_seen", found, 1);
    tick(5);
    check_vec("s6_echo_start_mid", a_txd, 0);
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(10);
      got[i] = a_txd;
      rdy_seen = rdy_seen | a_tx_ready;
    end
    check_vec("s6_echo_data", got, 8'h5A);
    check_vec("s6_tx_ready_low", rdy_seen, 0);
    check_vec("s6_rx_copy_data", a_rx_data, 8'h5A);
    check_vec("s6_rx_copy_count", a_rx_count, 1);
    check_vec("s6_busy_mid_frame", a_tx_busy, 1);
    resetn = 1'b0;
    tick(1);
    check_vec("s6_rst_txd", a_txd, 1);
    check_vec("s6_rst_counts", {a_rx_count, a_tx_count}, 0);
    check_vec("s6_rst_busy", a_tx_busy, 0);
    check_vec("s6_rst_valid", a_rx_valid, 0);
    check_vec("s6_rst_flags", {a_ovr, a_perr, a_ferr}, 0);
    resetn = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
